echo_capture: RTL and testbench
===============================

# echo_capture

Receive-side companion to the pulse sequencer: consumes the sequencer's `record_start` gate and a stream of ADC samples on the same 200 MHz PLL clock. It integrates the samples inside each gate window (one per pulse shot) and sums the per-shot integrals over a programmed number of shots. It then presents the averaged-echo total to the host readout through a valid/ready handshake.

## Interface
Parameters:
- `ADC_W`, 12: signed ADC sample width.
- `SHOT_W`, 16: shot-counter width.
- `CNT_W`, 12: per-shot sample-counter width.

Ports:
- `clk_pll` in 1: 200 MHz PLL clock; single clock domain.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: single-cycle pulse; begins an acquisition from IDLE.
- `abort` in 1: synchronous cancel; returns to IDLE with no result.
- `num_shots` in SHOT_W: shots to sum; 0 is treated as 1.
- `max_samples` in CNT_W: per-shot sample cap; 0 is treated as 1.
- `record_start` in 1: gate from the pulse sequencer; high during the record window.
- `adc_data` in ADC_W: signed two's-complement sample.
- `adc_valid` in 1: `adc_data` qualifier.
- `busy` out 1: high in any state except IDLE.
- `result_valid` out 1: total is available.
- `result_ready` in 1: host accepts the result.
- `result_sum` out ADC_W+CNT_W+SHOT_W (40): signed sum of all shot integrals.
- `result_samples` out CNT_W+SHOT_W (28): total accepted samples.
- `result_shots` out SHOT_W: shots completed.
- `clipped` out 1: sticky flag; some shot hit `max_samples`.

## Operation
- FSM states are IDLE, ARMED, INTEGRATE and DONE.
- IDLE → ARMED when `start` = 1.
  - On that transition, clear the shot sum, total sum, sample totals, shot count and `clipped`.
  - `start` is ignored in every other state.
- ARMED → INTEGRATE on a rising edge of `record_start`: current value 1 and registered previous value 0.
  - A gate that is already high when ARMED is entered does not count. The FSM waits for it to fall and rise again.
- INTEGRATE:
  - In each cycle with `record_start` = 1 and `adc_valid` = 1, and per-shot count < `max_samples`: add the sign-extended `adc_data` to the shot sum and increment the per-shot count.
  - A valid sample arriving at the cap is dropped and sets `clipped`.
- INTEGRATE ends on the first cycle with `record_start` = 0.
  - Add the shot sum into the total and add the per-shot count into the sample total.
  - Increment the shot count and clear the shot sum and per-shot count.
  - If the shot count equals the effective `num_shots`, go to DONE; otherwise go back to ARMED.
- DONE: hold `result_valid` = 1 with stable result outputs until `result_ready` = 1, then go to IDLE.
- `abort` = 1 forces IDLE from any state and clears `result_valid`. It has priority over `start` and over shot completion in the same cycle.
- Arithmetic: all sums are signed. The width rules make overflow impossible (4095 × 2047 × 65535 fits in 40 bits), so there is no saturation.

## Timing
- Reset values: `busy` = 0, `result_valid` = 0, `result_sum` = 0, `result_samples` = 0, `result_shots` = 0, `clipped` = 0, FSM = IDLE, previous-gate register = 0.
- `busy` rises the cycle after `start`.
- The first gate-high cycle is the edge-detect cycle and is not accumulated. Samples are accepted from the second gate-high cycle onward.
- `result_valid` rises 1 cycle after the last shot's gate falls.
- The handshake completes in the cycle where both `result_valid` and `result_ready` are high. `result_valid` is low on the next cycle.
- The result outputs keep their values after the handshake, until the next `start`.
- Minimum gate gap: a shot end followed by a new rising edge 1 cycle later must be captured, since ARMED is reached in time.

## Configuration
- `ECHO_BASELINE_EN`:
  - Defined: adds an input port `baseline` (signed ADC_W). Each accepted sample contributes `adc_data − baseline`, computed at ADC_W+1 bits before accumulation.
  - Undefined: no `baseline` port, and raw samples are accumulated.

## Structure
- `echo_capture_pkg` holds:
  - the width constants (ADC_W, CNT_W, SHOT_W and the derived sum widths);
  - the state enum `echo_state_t` {IDLE, ARMED, INTEGRATE, DONE};
  - a signed sign-extension helper function.
- Sub-module `gate_integrator`:
  - contains the edge detect, the per-shot sum/count with the cap and clip logic, and the shot-end strobe;
  - the top level holds the FSM, the cross-shot totals and the handshake.

## Test plan
- Basic: `num_shots` = 1, `max_samples` = 100; 10-cycle gate with `adc_valid` always high and `adc_data` = 5 → 9 accepted samples; `result_sum` = 45, `result_samples` = 9, `result_shots` = 1, `clipped` = 0.
- Multi-shot signed: `num_shots` = 3; gates of 5 cycles with `adc_data` = −2, 4 and 6 → `result_sum` = 4×(−2+4+6) = 32, `result_samples` = 12.
- Cap: `max_samples` = 3; 20-cycle gate with `adc_data` = 1 → `result_sum` = 3, `clipped` = 1.
- Pre-high gate: `record_start` is high when `start` arrives, then falls, then a 4-cycle gate occurs → only the second gate counts (3 samples).
- Backpressure and abort: hold `result_ready` = 0 for 10 cycles → outputs stable with `result_valid` held; a separate run aborted mid-INTEGRATE → IDLE, `result_valid` stays 0, `busy` = 0.
- Reset mid-shot: `resetn` = 0 during INTEGRATE → all outputs return to their reset values the next cycle; a fresh `start` yields a correct result.

Source files
------------

// File: rtl/echo_capture_pkg.sv
// Shared widths, FSM state type and sign-extension helper for echo_capture.
package echo_capture_pkg;

  localparam int unsigned ADC_W      = 12;
  localparam int unsigned CNT_W      = 12;
  localparam int unsigned SHOT_W     = 16;
  // One extra bit so a baseline-corrected sample cannot wrap.
  localparam int unsigned SAMP_W     = ADC_W + 1;
  localparam int unsigned SHOT_SUM_W = SAMP_W + CNT_W;
  localparam int unsigned SUM_W      = ADC_W + CNT_W + SHOT_W;
  localparam int unsigned TSAMP_W    = CNT_W + SHOT_W;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    INTEGRATE,
    DONE
  } echo_state_t;

  // Sign-extend an ADC sample by one bit.
  function automatic logic signed [SAMP_W-1:0] sext_sample(input logic signed [ADC_W-1:0] x);
    return {x[ADC_W-1], x};
  endfunction

endpackage

// File: rtl/echo_capture_gate_integrator.sv
// Per-shot integrator: gate edge detect, capped sample sum/count, clip strobe
// and shot-end strobe. Totals across shots live in the parent.
module gate_integrator #(
  parameter int unsigned SAMP_W     = 13,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned SHOT_SUM_W = 25
) (
  input  logic                         clk_pll,
  input  logic                         resetn,
  input  logic                         clear,
  input  logic                         accum_en,
  input  logic                         record_start,
  input  logic                         adc_valid,
  input  logic signed [SAMP_W-1:0]     sample,
  input  logic        [CNT_W-1:0]      cap,
  output logic                         gate_rise,
  output logic                         shot_end,
  output logic                         clip_hit,
  output logic signed [SHOT_SUM_W-1:0] shot_sum,
  output logic        [CNT_W-1:0]      shot_cnt
);

  logic                         gate_prev_q;
  logic signed [SHOT_SUM_W-1:0] sum_q;
  logic        [CNT_W-1:0]      cnt_q;
  logic                         offered;
  logic                         below_cap;
  logic                         accept;

  // Decode sample acceptance and the strobes seen by the parent FSM.
  always_comb begin
    offered   = accum_en & record_start & adc_valid;
    below_cap = (cnt_q < cap);
    accept    = offered & below_cap;
    clip_hit  = offered & ~below_cap;
    shot_end  = accum_en & ~record_start;
    gate_rise = record_start & ~gate_prev_q;
  end

  // Gate history plus per-shot accumulation; cleared at each shot end.
  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      gate_prev_q <= 1'b0;
      sum_q       <= '0;
      cnt_q       <= '0;
    end else begin
      gate_prev_q <= record_start;
      if (clear || shot_end) begin
        sum_q <= '0;
        cnt_q <= '0;
      end else if (accept) begin
        sum_q <= sum_q + {{(SHOT_SUM_W-SAMP_W){sample[SAMP_W-1]}}, sample};
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign shot_sum = sum_q;
  assign shot_cnt = cnt_q;

endmodule

// File: rtl/echo_capture.sv
// echo_capture: integrates ADC samples inside each record gate, sums the
// per-shot integrals over num_shots and hands the total to the host.
// Optional build macro ECHO_BASELINE_EN adds a baseline input subtracted
// from every accepted sample.
module echo_capture #(
  parameter int unsigned ADC_W  = 12,
  parameter int unsigned SHOT_W = 16,
  parameter int unsigned CNT_W  = 12
) (
  input  logic                                clk_pll,
  input  logic                                resetn,
  input  logic                                start,
  input  logic                                abort,
  input  logic        [SHOT_W-1:0]            num_shots,
  input  logic        [CNT_W-1:0]             max_samples,
  input  logic                                record_start,
  input  logic signed [ADC_W-1:0]             adc_data,
  input  logic                                adc_valid,
`ifdef ECHO_BASELINE_EN
  input  logic signed [ADC_W-1:0]             baseline,
`endif
  output logic                                busy,
  output logic                                result_valid,
  input  logic                                result_ready,
  output logic signed [ADC_W+CNT_W+SHOT_W-1:0] result_sum,
  output logic        [CNT_W+SHOT_W-1:0]       result_samples,
  output logic        [SHOT_W-1:0]             result_shots,
  output logic                                clipped
);

  import echo_capture_pkg::*;

  localparam int unsigned SampW    = ADC_W + 1;
  localparam int unsigned ShotSumW = SampW + CNT_W;
  localparam int unsigned SumW     = ADC_W + CNT_W + SHOT_W;
  localparam int unsigned TotSampW = CNT_W + SHOT_W;

  echo_state_t               state_q;
  logic                      busy_q;
  logic                      valid_q;
  logic signed [SumW-1:0]    total_sum_q;
  logic        [TotSampW-1:0] total_samp_q;
  logic        [SHOT_W-1:0]  shots_q;
  logic                      clipped_q;

  logic signed [SampW-1:0]    sample;
  logic        [CNT_W-1:0]    cap;
  logic        [SHOT_W-1:0]   eff_shots;
  logic                       clear_shot;
  logic                       accum_en;
  logic                       gate_rise;
  logic                       shot_end;
  logic                       clip_hit;
  logic signed [ShotSumW-1:0] shot_sum;
  logic        [CNT_W-1:0]    shot_cnt;

`ifdef ECHO_BASELINE_EN
  assign sample = sext_sample(adc_data) - sext_sample(baseline);
`else
  assign sample = sext_sample(adc_data);
`endif

  // Zero-valued limits behave as one; derive integrator controls from state.
  always_comb begin
    cap        = (max_samples == '0) ? CNT_W'(1) : max_samples;
    eff_shots  = (num_shots == '0) ? SHOT_W'(1) : num_shots;
    accum_en   = (state_q == INTEGRATE);
    clear_shot = abort | ((state_q == IDLE) & start);
  end

  gate_integrator #(
    .SAMP_W     (SampW),
    .CNT_W      (CNT_W),
    .SHOT_SUM_W (ShotSumW)
  ) u_gate_integrator (
    .clk_pll      (clk_pll),
    .resetn       (resetn),
    .clear        (clear_shot),
    .accum_en     (accum_en),
    .record_start (record_start),
    .adc_valid    (adc_valid),
    .sample       (sample),
    .cap          (cap),
    .gate_rise    (gate_rise),
    .shot_end     (shot_end),
    .clip_hit     (clip_hit),
    .shot_sum     (shot_sum),
    .shot_cnt     (shot_cnt)
  );

  // Acquisition FSM with cross-shot totals and the result handshake.
  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      total_sum_q  <= '0;
      total_samp_q <= '0;
      shots_q      <= '0;
      clipped_q    <= 1'b0;
    end else if (abort) begin
      // Totals are left as-is; the next start clears them.
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= ARMED;
            busy_q       <= 1'b1;
            total_sum_q  <= '0;
            total_samp_q <= '0;
            shots_q      <= '0;
            clipped_q    <= 1'b0;
          end
        end
        ARMED: begin
          if (gate_rise) state_q <= INTEGRATE;
        end
        INTEGRATE: begin
          if (clip_hit) clipped_q <= 1'b1;
          if (shot_end) begin
            total_sum_q  <= total_sum_q + {{(SumW-ShotSumW){shot_sum[ShotSumW-1]}}, shot_sum};
            total_samp_q <= total_samp_q + TotSampW'(shot_cnt);
            shots_q      <= shots_q + SHOT_W'(1);
            if ((shots_q + SHOT_W'(1)) == eff_shots) begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end else begin
              state_q <= ARMED;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign result_valid   = valid_q;
  assign result_sum     = total_sum_q;
  assign result_samples = total_samp_q;
  assign result_shots   = shots_q;
  assign clipped        = clipped_q;

endmodule

// File: tb/tb_echo_capture.sv
// Directed, table-driven bench for echo_capture.
module tb_echo_capture;

  logic               clk_pll = 1'b0;
  logic               resetn = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic        [15:0] num_shots = '0;
  logic        [11:0] max_samples = '0;
  logic               record_start = 1'b0;
  logic signed [11:0] adc_data = '0;
  logic               adc_valid = 1'b0;
  logic               busy;
  logic               result_valid;
  logic               result_ready = 1'b0;
  logic signed [39:0] result_sum;
  logic        [27:0] result_samples;
  logic        [15:0] result_shots;
  logic               clipped;
`ifdef ECHO_BASELINE_EN
  logic signed [11:0] baseline = '0;
`endif

  echo_capture dut (
    .clk_pll        (clk_pll),
    .resetn         (resetn),
    .start          (start),
    .abort          (abort),
    .num_shots      (num_shots),
    .max_samples    (max_samples),
    .record_start   (record_start),
    .adc_data       (adc_data),
    .adc_valid      (adc_valid),
`ifdef ECHO_BASELINE_EN
    .baseline       (baseline),
`endif
    .busy           (busy),
    .result_valid   (result_valid),
    .result_ready   (result_ready),
    .result_sum     (result_sum),
    .result_samples (result_samples),
    .result_shots   (result_shots),
    .clipped        (clipped)
  );

  always #5 clk_pll = ~clk_pll;

  typedef struct {
    logic        [15:0] shots;
    logic        [11:0] maxs;
    int                 gate_len;
    int                 gap;
    logic signed [11:0] d0;
    logic signed [11:0] d1;
    logic signed [11:0] d2;
    logic signed [39:0] e_sum;
    logic        [27:0] e_samp;
    logic        [15:0] e_shots;
    logic               e_clip;
  } vec_t;

  vec_t vecs[7];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic tick();
    @(posedge clk_pll);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [11:0] pick(input vec_t v, input int s);
    if (s == 0) return v.d0;
    else if (s == 1) return v.d1;
    else return v.d2;
  endfunction

  task automatic check_result(input string tag, input vec_t v);
    check({tag, ".result_valid"}, longint'(result_valid), 1);
    check({tag, ".result_sum"}, longint'(result_sum), longint'(v.e_sum));
    check({tag, ".result_samples"}, longint'(result_samples), longint'(v.e_samp));
    check({tag, ".result_shots"}, longint'(result_shots), longint'(v.e_shots));
    check({tag, ".clipped"}, longint'(clipped), longint'(v.e_clip));
  endtask

  // Start, drive every gate, then check the result one cycle after the last fall.
  task automatic run_acq(input string tag, input vec_t v);
    int ns;
    ns = (v.shots == 0) ? 1 : int'(v.shots);
    num_shots   = v.shots;
    max_samples = v.maxs;
    adc_valid   = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".busy_after_start"}, longint'(busy), 1);
    for (int s = 0; s < ns; s++) begin
      record_start = 1'b0;
      repeat ((s == 0) ? 2 : v.gap) tick();
      adc_data     = pick(v, s);
      record_start = 1'b1;
      repeat (v.gate_len) tick();
    end
    record_start = 1'b0;
    tick();
    check_result(tag, v);
  endtask

  task automatic handshake(input string tag, input vec_t v);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, ".valid_after_hs"}, longint'(result_valid), 0);
    check({tag, ".busy_after_hs"}, longint'(busy), 0);
    check({tag, ".sum_kept"}, longint'(result_sum), longint'(v.e_sum));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".busy"}, longint'(busy), 0);
    check({tag, ".result_valid"}, longint'(result_valid), 0);
    check({tag, ".result_sum"}, longint'(result_sum), 0);
    check({tag, ".result_samples"}, longint'(result_samples), 0);
    check({tag, ".result_shots"}, longint'(result_shots), 0);
    check({tag, ".clipped"}, longint'(clipped), 0);
  endtask

  initial begin
    vec_t pre;
    // shots, max, gate_len, gap, d0, d1, d2, sum, samples, shots, clip
    vecs[0] = '{16'd1, 12'd100, 10, 2, 12'sd5, 12'sd0, 12'sd0, 40'sd45, 28'd9, 16'd1, 1'b0};
    vecs[1] = '{16'd3, 12'd100, 5, 1, -12'sd2, 12'sd4, 12'sd6, 40'sd32, 28'd12, 16'd3, 1'b0};
    vecs[2] = '{16'd1, 12'd3, 20, 2, 12'sd1, 12'sd0, 12'sd0, 40'sd3, 28'd3, 16'd1, 1'b1};
    vecs[3] = '{16'd0, 12'd0, 4, 2, 12'sd7, 12'sd0, 12'sd0, 40'sd7, 28'd1, 16'd1, 1'b1};
    vecs[4] = '{16'd2, 12'd2, 3, 3, -12'sd5, -12'sd5, 12'sd0, -40'sd20, 28'd4, 16'd2, 1'b0};
    vecs[5] = '{16'd1, 12'd100, 1, 2, 12'sd9, 12'sd0, 12'sd0, 40'sd0, 28'd0, 16'd1, 1'b0};
    vecs[6] = '{16'd2, 12'd4095, 6, 1, -12'sd2048, 12'sd2047, 12'sd0, -40'sd5, 28'd10, 16'd2,
                1'b0};

    resetn = 1'b0;
    repeat (2) tick();
    check_reset_values("reset");
    resetn = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_acq($sformatf("vec%0d", i), vecs[i]);
      handshake($sformatf("vec%0d", i), vecs[i]);
      tick();
    end

    // Gate already high at start must be ignored; only the second gate counts.
    pre = '{16'd1, 12'd100, 4, 2, 12'sd3, 12'sd0, 12'sd0, 40'sd9, 28'd3, 16'd1, 1'b0};
    num_shots    = 16'd1;
    max_samples  = 12'd100;
    adc_valid    = 1'b1;
    adc_data     = 12'sd3;
    record_start = 1'b1;
    start        = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    record_start = 1'b0;
    repeat (2) tick();
    record_start = 1'b1;
    repeat (4) tick();
    record_start = 1'b0;
    tick();
    check_result("prehigh", pre);
    handshake("prehigh", pre);

    // Backpressure: result held stable while the host is not ready.
    run_acq("bp", vecs[0]);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("bp.valid_held", longint'(result_valid), 1);
      check("bp.sum_held", longint'(result_sum), 45);
    end
    handshake("bp", vecs[0]);

    // Abort mid-integration: no result, back to idle.
    num_shots   = 16'd1;
    max_samples = 12'd100;
    start       = 1'b1;
    tick();
    start        = 1'b0;
    record_start = 1'b0;
    tick();
    adc_data     = 12'sd5;
    record_start = 1'b1;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort.busy", longint'(busy), 0);
    check("abort.valid", longint'(result_valid), 0);
    repeat (3) tick();
    record_start = 1'b0;
    repeat (3) tick();
    check("abort.valid_later", longint'(result_valid), 0);
    check("abort.busy_later", longint'(busy), 0);

    // Abort wins over start in the same cycle.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_vs_start.busy", longint'(busy), 0);
    tick();

    // Reset mid-shot after a clipped result, then a fresh acquisition.
    run_acq("prerst", vecs[2]);
    handshake("prerst", vecs[2]);
    num_shots   = 16'd2;
    max_samples = 12'd100;
    start       = 1'b1;
    tick();
    start        = 1'b0;
    record_start = 1'b0;
    tick();
    record_start = 1'b1;
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    check_reset_values("midreset");
    resetn       = 1'b1;
    record_start = 1'b0;
    tick();
    run_acq("postrst", vecs[0]);
    handshake("postrst", vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1);
  end

endmodule
